// File: rtl/occ_pkg.sv
// Shared OCC table package: geometry of the OCC SRAM and the requester id type.
// Used by the read arbiter, the SRAM wrapper and the backward-search engines.
package occ_pkg;
  localparam int OCC_NUM_REQ    = 4;
  localparam int OCC_ADDR_WIDTH = 5;
  localparam int OCC_WIDTHS     = 1920;
  localparam int OCC_ID_W       = $clog2(OCC_NUM_REQ);

  typedef logic [OCC_ID_W-1:0] req_id_t;
endpackage

// File: rtl/occ_read_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with an internal rotating priority pointer.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (pointer returns to 0)
//   req        : per-requester request vector
//   en         : arbitration enable; when low no grant is issued
//   gnt        : one-hot grant (all zero when nothing is granted)
//   gnt_id     : encoded winner id (0 when nothing is granted)
// The scan starts at rr_ptr and wraps; after a grant the pointer moves to
// the slot just past the winner so the winner has lowest priority next time.
module rr_arbiter
  import occ_pkg::*;
#(
  parameter int NUM_REQ = OCC_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && en && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (found)
      rr_ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/occ_read_arbiter.sv
// occ_read_arbiter: shares the dual-read-port OCC SRAM among NUM_REQ
// backward-search engines and sequences the table-load write path.
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset
//   req_valid/req_ready      : per-engine lookup handshake (req_ready one-hot)
//   req_addr0/req_addr1      : per-engine low/high bound rows, packed by engine
//   ld_valid/ld_ready        : table-load handshake; ld_addr/ld_data row to write
//   sram_rEn/rAddr0/rAddr1   : SRAM read command (combinational, cycle T)
//   sram_wEn/wAddr/wData     : SRAM write command (combinational)
//   sram_rData0/1            : registered SRAM read data (cycle T+1)
//   rsp_valid/rsp_id         : lookup response strobe and owner, cycle T+1
//   rsp_data0/1              : SRAM read data pass-through
// Optional feature (macro OCC_ARB_STATS_EN): grant_cnt (32 bits per engine)
// and ld_stall_cnt (cycles where a load blocked pending lookups).
module occ_read_arbiter
  import occ_pkg::*;
#(
  parameter int NUM_REQ    = OCC_NUM_REQ,
  parameter int ID_W       = $clog2(NUM_REQ),
  parameter int ADDR_WIDTH = OCC_ADDR_WIDTH,
  parameter int WIDTHS     = OCC_WIDTHS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr0,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr1,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [ADDR_WIDTH-1:0]         ld_addr,
  input  logic [WIDTHS-1:0]             ld_data,
  output logic                          sram_rEn,
  output logic [ADDR_WIDTH-1:0]         sram_rAddr0,
  output logic [ADDR_WIDTH-1:0]         sram_rAddr1,
  output logic                          sram_wEn,
  output logic [ADDR_WIDTH-1:0]         sram_wAddr,
  output logic [WIDTHS-1:0]             sram_wData,
  input  logic [WIDTHS-1:0]             sram_rData0,
  input  logic [WIDTHS-1:0]             sram_rData1,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [WIDTHS-1:0]             rsp_data0,
  output logic [WIDTHS-1:0]             rsp_data1
`ifdef OCC_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]         grant_cnt,
  output logic [31:0]                   ld_stall_cnt
`endif
);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    win;
  logic               arb_en;
  logic               granted;

  // A pending load owns the SRAM for the cycle, so the read of the same row
  // in the following cycle observes the freshly written data.
  assign arb_en = rst_n && !ld_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (win)
  );

  assign granted   = |gnt;
  assign req_ready = gnt;
  assign ld_ready  = rst_n;

  always_comb begin
    sram_rEn    = granted;
    sram_rAddr0 = '0;
    sram_rAddr1 = '0;
    if (granted) begin
      sram_rAddr0 = req_addr0[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
      sram_rAddr1 = req_addr1[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign sram_wEn   = ld_valid && rst_n;
  assign sram_wAddr = ld_addr;
  assign sram_wData = ld_data;

  // Response tracking: one stage matching the SRAM read latency.
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  always_comb begin
    rsp_valid_d = granted;
    rsp_id_d    = win;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data0 = sram_rData0;
  assign rsp_data1 = sram_rData1;

`ifdef OCC_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]              ld_stall_cnt_q, ld_stall_cnt_d;

  always_comb begin
    grant_cnt_d    = grant_cnt_q;
    ld_stall_cnt_d = ld_stall_cnt_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
    if (ld_valid && (|req_valid))
      ld_stall_cnt_d = ld_stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt_q    <= '0;
      ld_stall_cnt_q <= '0;
    end else begin
      grant_cnt_q    <= grant_cnt_d;
      ld_stall_cnt_q <= ld_stall_cnt_d;
    end
  end

  assign grant_cnt    = grant_cnt_q;
  assign ld_stall_cnt = ld_stall_cnt_q;
`endif

endmodule

// File: tb/tb_occ_read_arbiter.sv
module tb_occ_read_arbiter;
  import occ_pkg::*;

  localparam int N  = OCC_NUM_REQ;
  localparam int AW = OCC_ADDR_WIDTH;
  localparam int W  = OCC_WIDTHS;
  localparam int IW = OCC_ID_W;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      rv;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   a0, a1;
  logic              ldv;
  logic              ld_ready;
  logic [AW-1:0]     lda;
  logic [W-1:0]      ldd;
  logic              sram_rEn, sram_wEn;
  logic [AW-1:0]     sram_rAddr0, sram_rAddr1, sram_wAddr;
  logic [W-1:0]      sram_wData, sram_rData0, sram_rData1;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_data0, rsp_data1;
`ifdef OCC_ARB_STATS_EN
  logic [N*32-1:0]   grant_cnt;
  logic [31:0]       ld_stall_cnt;
`endif

  occ_read_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv), .req_ready(req_ready),
    .req_addr0(a0), .req_addr1(a1),
    .ld_valid(ldv), .ld_ready(ld_ready), .ld_addr(lda), .ld_data(ldd),
    .sram_rEn(sram_rEn), .sram_rAddr0(sram_rAddr0), .sram_rAddr1(sram_rAddr1),
    .sram_wEn(sram_wEn), .sram_wAddr(sram_wAddr), .sram_wData(sram_wData),
    .sram_rData0(sram_rData0), .sram_rData1(sram_rData1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1)
`ifdef OCC_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .ld_stall_cnt(ld_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: behavioural dual-read-port SRAM with registered outputs.
  logic [W-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (sram_wEn) mem[sram_wAddr] <= sram_wData;
    if (sram_rEn) begin
      sram_rData0 <= mem[sram_rAddr0];
      sram_rData1 <= mem[sram_rAddr1];
    end
  end

  // Reference model state.
  logic [W-1:0] shadow [2**AW];
  int           m_ptr;
  logic         m_rv;
  int           m_id;
  logic [W-1:0] m_d0, m_d1;
  int unsigned  m_gcnt [N];
  int unsigned  m_stall;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (low 64 bits)", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Winner = valid engine with the smallest forward distance from the pointer.
  function automatic int exp_winner(input logic [N-1:0] v, input int p);
    int best, bestd, d;
    best = -1; bestd = N;
    for (int i = 0; i < N; i++)
      if (v[i]) begin
        d = (i - p + N) % N;
        if (d < bestd) begin bestd = d; best = i; end
      end
    return best;
  endfunction

  // One clock: inputs already driven just after a falling edge.
  task automatic step();
    int w;
    logic g;
    logic [N-1:0] eg;
    logic [AW-1:0] ea0, ea1;
    #1;
    w   = exp_winner(rv, m_ptr);
    g   = rst_n && !ldv && (w >= 0);
    eg  = '0;
    ea0 = '0;
    ea1 = '0;
    if (g) begin
      eg[w] = 1'b1;
      ea0 = a0[w*AW +: AW];
      ea1 = a1[w*AW +: AW];
    end
    chk("req_ready", req_ready, eg);
    chk("ld_ready", ld_ready, rst_n);
    chk("rEn", sram_rEn, g);
    chk("rAddr0", sram_rAddr0, ea0);
    chk("rAddr1", sram_rAddr1, ea1);
    chk("wEn", sram_wEn, ldv && rst_n);
    if (ldv && rst_n) begin
      chk("wAddr", sram_wAddr, lda);
      chk("wData", sram_wData, ldd);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_rv = 1'b0; m_stall = 0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    end else begin
      m_rv = g;
      if (g) begin
        m_ptr = (w + 1) % N;
        m_id  = w;
        m_d0  = shadow[ea0];
        m_d1  = shadow[ea1];
        m_gcnt[w]++;
      end
      if (ldv) shadow[lda] = ldd;
      if (ldv && (|rv)) m_stall++;
    end
    #1;
    chk("rsp_valid", rsp_valid, m_rv);
    if (m_rv) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_data0", rsp_data0, m_d0);
      chk("rsp_data1", rsp_data1, m_d1);
    end
`ifdef OCC_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*32 +: 32], m_gcnt[i]);
    chk("ld_stall_cnt", ld_stall_cnt, m_stall);
`endif
    @(negedge clk);
  endtask

  logic [W-1:0] row_a, row_b, row_c;
  logic [N-1:0] one_hot;

  initial begin
    for (int i = 0; i < 2**AW; i++) begin mem[i] = '0; shadow[i] = '0; end
    m_ptr = 0; m_rv = 1'b0; m_id = 0; m_stall = 0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    rst_n = 1'b0; rv = '1; a0 = '0; a1 = '0; ldv = 1'b0; lda = '0; ldd = '0;

    // Reset held 3 cycles with all engines requesting.
    repeat (3) step();
    chk("reset_rsp_id", rsp_id, 0);

    // Round-robin with all engines active.
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      one_hot = '0; one_hot[k % N] = 1'b1;
      chk("rr_seq_id", rsp_id, k % N);
    end

    // Preload rows 5 and 9, then engine 2 looks them up.
    row_a = rnd_row(); row_b = rnd_row(); row_c = rnd_row();
    rv = '0; ldv = 1'b1; lda = 5; ldd = row_a; step();
    lda = 9; ldd = row_b; step();
    ldv = 1'b0;
    rv = 4'b0100; a0[2*AW +: AW] = 5; a1[2*AW +: AW] = 9; step();
    chk("lookup_valid", rsp_valid, 1);
    chk("lookup_id", rsp_id, 2);
    chk("lookup_d0", rsp_data0, row_a);
    chk("lookup_d1", rsp_data1, row_b);

    // Load blocks engine 1 for a cycle; its read then sees the new row.
    rv = 4'b0010; a0[1*AW +: AW] = 5; ldv = 1'b1; lda = 5; ldd = row_c; step();
    chk("ldprio_nogrant", req_ready, 0);
    ldv = 1'b0; step();
    chk("ldprio_id", rsp_id, 1);
    chk("ldprio_d0", rsp_data0, row_c);

    // Move pointer to 3, then 0101 must grant 0 then 2.
    rv = 4'b0100; step();
    rv = 4'b0101; step();
    chk("wrap_first", rsp_id, 0);
    step();
    chk("wrap_second", rsp_id, 2);

    // Reset while a grant is being requested.
    rv = 4'b1111; rst_n = 1'b0; step();
    chk("midrst_valid", rsp_valid, 0);
`ifdef OCC_ARB_STATS_EN
    chk("stats_rst", grant_cnt, 0);
`endif
    rst_n = 1'b1; rv = 4'b0010;
    repeat (4) step();
    chk("midrst_id", rsp_id, 1);
`ifdef OCC_ARB_STATS_EN
    chk("stats_eng1", grant_cnt[32 +: 32], 4);
`endif
    rv = 4'b1111; step();
    chk("after_rst_ptr", rsp_id, 2);

    // Randomized traffic with occasional loads and resets.
    for (int k = 0; k < 400; k++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      rv    = N'($urandom);
      a0    = (N*AW)'({$urandom, $urandom});
      a1    = (N*AW)'({$urandom, $urandom});
      ldv   = rst_n && ($urandom_range(0, 3) == 0);
      lda   = AW'($urandom);
      ldd   = rnd_row();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
